// File: rtl/id_stage_pipe.sv
// Instruction decode stage: register file with optional write bypass, immediate
// extension, RAW hazard stall and a single-entry valid/ready output register.
module id_stage_pipe #(
    parameter int unsigned N      = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] instruction,
    input  logic         rb_selector,
    input  logic [1:0]   ext_selector,
    input  logic         we,
    input  logic [4:0]   wa,
    input  logic [N-1:0] wd,
    input  logic         hz_valid,
    input  logic [4:0]   hz_rd,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   op,
    output logic [1:0]   func,
    output logic [4:0]   rd,
    output logic [N-1:0] rda,
    output logic [N-1:0] rdb,
    output logic [N-1:0] extended
);

    logic [2:0]   f_op;
    logic [4:0]   f_rf;
    logic [4:0]   f_ra;
    logic [4:0]   f_rb;
    logic [1:0]   f_func;
    logic [4:0]   b_idx;
    logic [N-1:0] rda_c;
    logic [N-1:0] rdb_c;
    logic [N-1:0] ext_c;
    logic         stall;
    logic         load;

    logic [N-1:0] regs_q [NREG];
    logic [N-1:0] regs_d [NREG];

    logic         out_valid_q, out_valid_d;
    logic [2:0]   op_q, op_d;
    logic [1:0]   func_q, func_d;
    logic [4:0]   rd_q, rd_d;
    logic [N-1:0] rda_q, rda_d;
    logic [N-1:0] rdb_q, rdb_d;
    logic [N-1:0] extended_q, extended_d;

    assign f_op   = instruction[31:29];
    assign f_rf   = instruction[28:24];
    assign f_ra   = instruction[23:19];
    assign f_rb   = instruction[18:14];
    assign f_func = instruction[1:0];
    assign b_idx  = rb_selector ? f_rf : f_rb;

    // Indices at or above NREG match no entry, so they read 0 and writes to them vanish.
    always_comb begin
        rda_c = '0;
        rdb_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (f_ra == 5'(i)) rda_c = regs_q[i];
            if (b_idx == 5'(i)) rdb_c = regs_q[i];
            regs_d[i] = (we && wa == 5'(i)) ? wd : regs_q[i];
        end
        if (BYPASS && we && (32'(wa) < NREG)) begin
            if (wa == f_ra)  rda_c = wd;
            if (wa == b_idx) rdb_c = wd;
        end
    end

    always_comb begin
        ext_c = '0;
        case (ext_selector)
            2'b00:   ext_c = {{(N-29){1'b0}}, instruction[28:0]};
            2'b01:   ext_c = {{(N-29){instruction[28]}}, instruction[28:0]};
            2'b10:   ext_c = {{(N-14){1'b0}}, instruction[13:0]};
            default: ext_c = {{(N-14){instruction[13]}}, instruction[13:0]};
        endcase
    end

    assign stall    = hz_valid && (hz_rd == f_ra || hz_rd == b_idx);
    assign in_ready = !stall && (!out_valid_q || out_ready);
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        func_d      = func_q;
        rd_d        = rd_q;
        rda_d       = rda_q;
        rdb_d       = rdb_q;
        extended_d  = extended_q;
        if (load) begin
            op_d       = f_op;
            func_d     = f_func;
            rd_d       = f_rf;
            rda_d      = rda_c;
            rdb_d      = rdb_c;
            extended_d = ext_c;
        end
        if (flush)          out_valid_d = 1'b0;
        else if (load)      out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            func_q      <= '0;
            rd_q        <= '0;
            rda_q       <= '0;
            rdb_q       <= '0;
            extended_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            func_q      <= func_d;
            rd_q        <= rd_d;
            rda_q       <= rda_d;
            rdb_q       <= rdb_d;
            extended_q  <= extended_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;
    assign func      = func_q;
    assign rd        = rd_q;
    assign rda       = rda_q;
    assign rdb       = rdb_q;
    assign extended  = extended_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: reference model of the decode slot checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_id_stage_pipe;

    localparam int unsigned N      = 32;
    localparam int unsigned NREG   = 32;
    localparam bit          BYPASS = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] instruction;
    logic        rb_selector;
    logic [1:0]  ext_selector;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hz_valid;
    logic [4:0]  hz_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [2:0]  op;
    logic [1:0]  func;
    logic [4:0]  rd;
    logic [31:0] rda, rdb, extended;

    id_stage_pipe #(.N(N), .NREG(NREG), .BYPASS(BYPASS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .rb_selector(rb_selector), .ext_selector(ext_selector),
        .we(we), .wa(wa), .wd(wd), .hz_valid(hz_valid), .hz_rd(hz_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .op(op), .func(func), .rd(rd),
        .rda(rda), .rdb(rdb), .extended(extended)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents and the one-entry output slot.
    logic [31:0] mrf [32];
    logic        m_ov;
    logic [2:0]  m_op;
    logic [1:0]  m_func;
    logic [4:0]  m_rd;
    logic [31:0] m_rda, m_rdb, m_ext;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (int'(idx) >= int'(NREG)) return 32'h0;
        if (BYPASS && we && wa == idx) return wd;
        return mrf[idx];
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] ins, input logic [1:0] sel);
        logic [31:0] c, s;
        c = ins & 32'h1FFF_FFFF;
        s = ins & 32'h0000_3FFF;
        case (sel)
            2'd0: return c;
            2'd1: return (c >= 32'h1000_0000) ? c - 32'h2000_0000 : c;
            2'd2: return s;
            default: return (s >= 32'h2000) ? s - 32'h4000 : s;
        endcase
    endfunction

    function automatic logic model_ready();
        logic [4:0] a, b;
        a = instruction[23:19];
        b = rb_selector ? instruction[28:24] : instruction[18:14];
        if (hz_valid && (hz_rd == a || hz_rd == b)) return 1'b0;
        return !m_ov || out_ready;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        m_ov = 0; m_op = 0; m_func = 0; m_rd = 0; m_rda = 0; m_rdb = 0; m_ext = 0;
    endtask

    always @(negedge reset) model_clear();

    always @(posedge clk) begin
        if (reset) begin
            logic take;
            take = in_valid && model_ready() && !flush;
            if (take) begin
                m_op   = instruction[31:29];
                m_func = instruction[1:0];
                m_rd   = instruction[28:24];
                m_rda  = model_read(instruction[23:19]);
                m_rdb  = model_read(rb_selector ? instruction[28:24] : instruction[18:14]);
                m_ext  = model_ext(instruction, ext_selector);
            end
            if (flush) m_ov = 0;
            else if (take) m_ov = 1;
            else if (out_ready) m_ov = 0;
            if (we && int'(wa) < int'(NREG)) mrf[wa] = wd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            check("m_in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
            check("m_op", {29'b0, op}, {29'b0, m_op});
            check("m_func", {30'b0, func}, {30'b0, m_func});
            check("m_rd", {27'b0, rd}, {27'b0, m_rd});
            check("m_rda", rda, m_rda);
            check("m_rdb", rdb, m_rdb);
            check("m_extended", extended, m_ext);
        end
    end

    function automatic logic [31:0] mk(input logic [2:0] o, input logic [4:0] f,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [1:0] fn);
        return {o, f, a, b, 12'b0, fn};
    endfunction

    task automatic cycle();
        @(negedge clk);
        #2;
    endtask

    initial begin
        model_clear();
        reset = 0; in_valid = 0; instruction = 0; rb_selector = 0; ext_selector = 0;
        we = 0; wa = 0; wd = 0; hz_valid = 0; hz_rd = 0; flush = 0; out_ready = 1;
        cycle(); cycle();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_rda", rda, 32'h0);
        check("rst_extended", extended, 32'h0);
        reset = 1;
        chk_en = 1;

        // r3 = 0xAA, then decode op=2 rf=1 ra=3 rb=0
        we = 1; wa = 3; wd = 32'hAA;
        cycle();
        we = 0; in_valid = 1; instruction = mk(3'b010, 5'd1, 5'd3, 5'd0, 2'd0); ext_selector = 2'b00;
        cycle();
        check("lit_load_valid", {31'b0, out_valid}, 32'h1);
        check("lit_load_rda", rda, 32'hAA);
        check("lit_load_rd", {27'b0, rd}, 32'd1);
        check("lit_load_op", {29'b0, op}, 32'd2);

        instruction = 32'h1000_0000; ext_selector = 2'b01;
        cycle();
        check("lit_ext01", extended, 32'hF000_0000);
        instruction = 32'h0000_2000; ext_selector = 2'b11;
        cycle();
        check("lit_ext11", extended, 32'hFFFF_E000);
        ext_selector = 2'b10;
        cycle();
        check("lit_ext10", extended, 32'h0000_2000);

        // Bypass: write r5 while loading an instruction that reads it
        in_valid = 0; we = 1; wa = 5; wd = 32'h55; ext_selector = 2'b00;
        cycle();
        wd = 32'h1234; in_valid = 1; instruction = mk(3'b000, 5'd4, 5'd5, 5'd0, 2'd0);
        cycle();
        check("lit_bypass_rda", rda, BYPASS ? 32'h1234 : 32'h55);

        // Hazard on ra
        we = 0; hz_valid = 1; hz_rd = 5;
        #1;
        check("lit_hz_ready", {31'b0, in_ready}, 32'h0);
        cycle();
        check("lit_hz_noload", {31'b0, out_valid}, 32'h0);
        hz_valid = 0;
        cycle();
        check("lit_hz_release", {31'b0, out_valid}, 32'h1);
        check("lit_hz_rda", rda, 32'h1234);

        // Hold for three cycles
        out_ready = 0; instruction = mk(3'b111, 5'd9, 5'd1, 5'd2, 2'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lit_hold_ready", {31'b0, in_ready}, 32'h0);
            cycle();
            check("lit_hold_rd", {27'b0, rd}, 32'd4);
            check("lit_hold_rda", rda, 32'h1234);
        end
        out_ready = 1;

        // Back-to-back stream
        for (int i = 10; i < 16; i++) begin
            instruction = mk(3'b001, 5'(i), 5'(i - 8), 5'(i - 7), 2'(i));
            cycle();
            check("lit_stream_valid", {31'b0, out_valid}, 32'h1);
            check("lit_stream_rd", {27'b0, rd}, 32'(i));
        end

        flush = 1;
        cycle();
        check("lit_flush", {31'b0, out_valid}, 32'h0);
        flush = 0;

        for (int i = 0; i < 80; i++) begin
            instruction  = $urandom;
            in_valid     = 1'($urandom_range(0, 3) != 0);
            rb_selector  = 1'($urandom_range(0, 1));
            ext_selector = 2'($urandom_range(0, 3));
            we           = 1'($urandom_range(0, 1));
            wa           = 5'($urandom_range(0, 31));
            wd           = $urandom;
            hz_valid     = 1'($urandom_range(0, 4) == 0);
            hz_rd        = ($urandom_range(0, 1) != 0) ? instruction[23:19] : 5'($urandom_range(0, 31));
            flush        = 1'($urandom_range(0, 9) == 0);
            out_ready    = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset mid-stream
        hz_valid = 0; flush = 0; out_ready = 1; in_valid = 1; we = 0;
        instruction = mk(3'b101, 5'd7, 5'd3, 5'd3, 2'd1);
        cycle();
        reset = 0;
        #1;
        check("lit_rst_valid", {31'b0, out_valid}, 32'h0);
        check("lit_rst_rda", rda, 32'h0);
        check("lit_rst_rd", {27'b0, rd}, 32'h0);
        check("lit_rst_ext", extended, 32'h0);
        in_valid = 0;
        cycle();
        reset = 1; in_valid = 1; ext_selector = 2'b00;
        instruction = mk(3'b000, 5'd2, 5'd3, 5'd3, 2'd0);
        cycle();
        check("lit_post_rst_valid", {31'b0, out_valid}, 32'h1);
        check("lit_post_rst_r3", rda, 32'h0);
        in_valid = 0;
        cycle();
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter N, default 32: datapath and instruction width, legal only as 32 (fixed field layout).
REQ-002 Parameter NREG, default 32: register-file depth, 2..32; index field stays 5 bits.
REQ-003 Parameter BYPASS, default 1: 1 enables same-cycle writeback-to-read bypass, 0 disables it.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  in  1  instruction present; in_ready  out  1  stage accepts instruction this cycle.
REQ-007 instruction  in  N  word to decode.
REQ-008 rb_selector  in  1  0: port B reads rb field, 1: port B reads rf field.
REQ-009 ext_selector  in  2  immediate extension mode.
REQ-010 we  in  1  writeback enable; wa  in  5  writeback index; wd  in  N  writeback data.
REQ-011 hz_valid  in  1  a younger in-flight write is pending; hz_rd  in  5  its destination index.
REQ-012 flush  in  1  discard held and incoming instruction.
REQ-013 out_valid  out  1  decoded bundle valid; out_ready  in  1  downstream accepts bundle.
REQ-014 op  out  3; func  out  2; rd  out  5; rda  out  N; rdb  out  N; extended  out  N; all registered.

Function
REQ-015 Fields: op=[31:29], rf=[28:24], ra=[23:19], rb=[18:14], func=[1:0], constant=[28:0], short=[13:0].
REQ-016 Register file: NREG x N flops, write on rising clk when we=1 and wa<NREG; all registers writable.
REQ-017 Reads combinational; index >= NREG reads 0; writes to index >= NREG ignored.
REQ-018 BYPASS=1: if we=1 and wa equals a read index (<NREG), that port returns wd same cycle; BYPASS=0: returns old value.
REQ-019 ext_selector: 00 zero-extend constant; 01 sign-extend constant (bit 28); 10 zero-extend short; 11 sign-extend short (bit 13).
REQ-020 Hazard: stall=1 when hz_valid=1 and hz_rd equals ra or the selected port-B index; index 0 not exempt.
REQ-021 in_ready = !stall && (!out_valid || out_ready); combinational, independent of in_valid.
REQ-022 Load: in_valid && in_ready && !flush captures op, func, rd=rf, rda, rdb, extended, sets out_valid=1 next cycle.
REQ-023 Hold: out_valid=1 and out_ready=0 keeps all outputs stable, no load.
REQ-024 Drain: out_valid=1, out_ready=1, no load -> out_valid=0 next cycle; data outputs retain last value.
REQ-025 Simultaneous drain and load -> new bundle replaces old in one cycle, out_valid stays 1 (full throughput).
REQ-026 flush=1 -> out_valid=0 next cycle, overrides load and hold; register file writes still occur.
REQ-027 Writeback and load same cycle: captured rda/rdb follow REQ-018.
REQ-028 Latency: accepted instruction appears on outputs exactly 1 cycle later.

Reset
REQ-029 reset=0 asynchronously clears out_valid, op, func, rd, rda, rdb, extended and every register to 0.
REQ-030 Reset mid-operation drops any held bundle; first load allowed on the first rising clk after reset=1.
REQ-031 in_ready during reset follows REQ-021 with out_valid=0; no load occurs while reset=0.

Verification
REQ-032 Write r3=0x0000_00AA, then instruction op=3'b010,rf=1,ra=3,rb=0, ext=00 -> next cycle rda=0xAA, rd=1, out_valid=1.
REQ-033 constant=0x1000_0000 ext=01 -> extended=0xF000_0000; short=0x2000 ext=11 -> 0xFFFF_E000; ext=10 -> 0x0000_2000.
REQ-034 we=1,wa=5,wd=0x1234 same cycle as load reading ra=5 -> rda=0x1234 (BYPASS=1), previous r5 value (BYPASS=0).
REQ-035 hz_valid=1,hz_rd=5, instruction ra=5 -> in_ready=0 and no load; hz_valid=0 -> loaded next cycle.
REQ-036 out_ready=0 for 3 cycles -> outputs stable, in_ready=0; back-to-back stream with out_ready=1 -> one bundle per cycle.
REQ-037 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; reset=0 mid-stream -> all outputs 0 immediately, r3 reads 0.
